rle_idwt_decoder: RTL and testbench
===================================

// Module: rle_idwt_decoder
// PURPOSE
//   Decompression path for the EEG compressor. Accepts two run-length-coded
//   streams of (value, count) pairs, the DWT average band and the difference band,
//   and expands each stream back to one coefficient per sample. It then applies the
//   inverse Haar step and emits reconstructed sample pairs (sample1, sample2) over a
//   valid/ready handshake.
// PARAMETERS
//   W   8  width of signed coefficients and reconstructed samples
//   CW  8  width of unsigned run-length counts
// PORTS
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   avg_val    in   W   signed average-band run value
//   avg_cnt    in   CW  average-band run length (repetitions of avg_val)
//   avg_valid  in   1   avg_val/avg_cnt pair is valid
//   avg_ready  out  1   decoder accepts the avg pair this cycle
//   dif_val    in   W   signed difference-band run value
//   dif_cnt    in   CW  difference-band run length
//   dif_valid  in   1   dif pair is valid
//   dif_ready  out  1   decoder accepts the dif pair this cycle
//   sample1    out  W   reconstructed sample = sat(avg + dif)
//   sample2    out  W   reconstructed sample = sat(avg - dif)
//   sat        out  1   sample1 or sample2 was clipped in this output beat
//   out_valid  out  1   sample1/sample2/sat valid
//   out_ready  in   1   downstream accepts the output beat
// BEHAVIOUR
// - Reset (async, rst_n=0): the remaining-count registers rem_a and rem_d go to 0.
//   The held values go to 0. out_valid, sample1, sample2 and sat all go to 0.
// - Each channel (a = avg, d = dif) is an expander with two states:
//   EMPTY (rem==0) and RUN (rem>0).
// - Channel handshake: a pair is accepted when valid && ready.
//   - avg_ready = (rem_a==0) || (rem_a==1 && pop). dif_ready uses the same rule.
//   - ready is combinational on out_ready. valid must not depend on ready.
// - On accept: hold <= val and rem <= cnt.
//   - A pair with cnt==0 is accepted and discarded, and the channel stays EMPTY.
// - pop = (rem_a>0) && (rem_d>0) && (!out_valid || out_ready).
//   - On pop, each channel decrements rem unless it reloads in the same cycle.
//   - A reload overrides the decrement, which gives gapless back-to-back runs.
//   - When rem reaches 0 with no reload, the channel returns to EMPTY.
// - Output register, updated on pop:
//   - sample1 <= sat(hold_a + hold_d) and sample2 <= sat(hold_a - hold_d).
//   - Both sums use W+1-bit arithmetic and clip to [-2^(W-1), 2^(W-1)-1].
//   - sat <= 1 if either result clipped.
//   - out_valid <= 1.
// - If out_valid && out_ready && !pop, then out_valid <= 0.
//   While out_valid && !out_ready, all outputs hold stable.
// - Latency: a pair accepted on edge t (both channels loaded) gives out_valid=1
//   after edge t+1.
// - Steady-state throughput is 1 beat per cycle while both channels stay non-empty.
// - Band misalignment (runs of unequal length) is normal. The channel whose run
//   ends first stalls pop until it is reloaded, and the other channel holds its
//   value and count.
// - A channel whose valid stays low stalls the output indefinitely. No timeout.
// - Run lengths of up to 2^CW-1 are supported. The counter never wraps, because
//   the decrement is gated by rem>0.
// - Reset mid-run: partial runs are dropped, and the next accepted pairs start clean.
// TESTING
// - T1: avg(10,3) and dif(2,3) with out_ready=1 -> 3 consecutive beats of
//   (12,8) with sat=0, out_valid falling after the 3rd.
// - T2: avg(5,4) and dif(1,1),(-1,3) back-to-back -> (6,4), then 3x(4,6) with no
//   bubble. dif_ready must be high in the pop cycle where rem_d==1.
// - T3: cnt==0 pair dif(7,0) followed by dif(3,2), with avg(0,2) -> the 7 never
//   appears. Outputs are (3,-3),(3,-3).
// - T4: saturation with avg(100,1), dif(100,1) -> sample1=127, sample2=0, sat=1.
//   avg(-128,1), dif(1,1) -> sample1=-127, sample2=-128, sat=1.
// - T5: backpressure with out_ready=0 for 4 cycles mid-run of avg(20,5), dif(0,5)
//   -> outputs are held stable, there is no loss or duplication, and exactly 5
//   beats of (20,20) are delivered.
// - T6: assert rst_n=0 asynchronously mid-run of avg(9,200) -> out_valid=0 and
//   rem=0 immediately, without waiting for a clock edge. After release, new pairs
//   avg(1,1), dif(1,1) give a single beat of (2,0).

Source files
------------

// File: rtl/rle_idwt_decoder_if.sv
// Handshake bundle for the RLE + inverse-Haar decoder: two run-length input
// streams (average and difference bands) and the reconstructed sample-pair output.
interface rle_idwt_decoder_if #(
    parameter int W  = 8,
    parameter int CW = 8
);
    logic signed [W-1:0]  avg_val;
    logic        [CW-1:0] avg_cnt;
    logic                 avg_valid;
    logic                 avg_ready;
    logic signed [W-1:0]  dif_val;
    logic        [CW-1:0] dif_cnt;
    logic                 dif_valid;
    logic                 dif_ready;
    logic signed [W-1:0]  sample1;
    logic signed [W-1:0]  sample2;
    logic                 sat;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output avg_val, avg_cnt, avg_valid, input avg_ready,
        output dif_val, dif_cnt, dif_valid, input dif_ready,
        input  sample1, sample2, sat, out_valid,
        output out_ready
    );

    modport slave (
        input  avg_val, avg_cnt, avg_valid, output avg_ready,
        input  dif_val, dif_cnt, dif_valid, output dif_ready,
        output sample1, sample2, sat, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/rle_idwt_decoder.sv
// Expands run-length coded average/difference bands to one coefficient per sample
// and applies the inverse Haar step, emitting saturated sample pairs.
module rle_idwt_decoder #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input logic               clk,
    input logic               rst_n,
    rle_idwt_decoder_if.slave bus
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    // Clip a W+1-bit two's-complement result to the W-bit signed range.
    function automatic logic [W-1:0] sat_fn(input logic [W:0] x);
        logic [W-1:0] r;
        if (x[W] != x[W-1]) begin
            r = x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            r = x[W-1:0];
        end
        return r;
    endfunction

    function automatic logic clip_fn(input logic [W:0] x);
        return x[W] ^ x[W-1];
    endfunction

    logic [CW-1:0] rem_a_r, rem_d_r;
    logic [W-1:0]  hold_a_r, hold_d_r;
    logic [W-1:0]  sample1_r, sample2_r;
    logic          sat_r, out_valid_r;

    logic          pop_s;
    logic          avg_ready_s, dif_ready_s;
    logic          acc_a_s, acc_d_s;
    logic [W:0]    sum_s, diff_s;

    // Pop / ready / accept decode and the widened inverse-Haar arithmetic.
    always_comb begin
        pop_s       = 1'b0;
        avg_ready_s = 1'b0;
        dif_ready_s = 1'b0;
        acc_a_s     = 1'b0;
        acc_d_s     = 1'b0;
        sum_s       = {(W+1){1'b0}};
        diff_s      = {(W+1){1'b0}};
        if ((rem_a_r != CNT_ZERO) && (rem_d_r != CNT_ZERO)) begin
            pop_s = !out_valid_r || bus.out_ready;
        end else begin
            pop_s = 1'b0;
        end
        // A channel on its last count may reload in the same cycle it pops.
        avg_ready_s = (rem_a_r == CNT_ZERO) || ((rem_a_r == CNT_ONE) && pop_s);
        dif_ready_s = (rem_d_r == CNT_ZERO) || ((rem_d_r == CNT_ONE) && pop_s);
        acc_a_s     = bus.avg_valid && avg_ready_s;
        acc_d_s     = bus.dif_valid && dif_ready_s;
        sum_s       = {hold_a_r[W-1], hold_a_r} + {hold_d_r[W-1], hold_d_r};
        diff_s      = {hold_a_r[W-1], hold_a_r} - {hold_d_r[W-1], hold_d_r};
    end

    // Average-band expander: reload takes priority over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_a_r  <= CNT_ZERO;
            hold_a_r <= {W{1'b0}};
        end else if (acc_a_s) begin
            hold_a_r <= bus.avg_val;
            rem_a_r  <= bus.avg_cnt;
        end else if (pop_s) begin
            rem_a_r  <= rem_a_r - CNT_ONE;
        end
    end

    // Difference-band expander, same rules as the average band.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_d_r  <= CNT_ZERO;
            hold_d_r <= {W{1'b0}};
        end else if (acc_d_s) begin
            hold_d_r <= bus.dif_val;
            rem_d_r  <= bus.dif_cnt;
        end else if (pop_s) begin
            rem_d_r  <= rem_d_r - CNT_ONE;
        end
    end

    // Output register: loads on pop, drops valid once consumed without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample1_r   <= {W{1'b0}};
            sample2_r   <= {W{1'b0}};
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (pop_s) begin
            sample1_r   <= sat_fn(sum_s);
            sample2_r   <= sat_fn(diff_s);
            sat_r       <= clip_fn(sum_s) | clip_fn(diff_s);
            out_valid_r <= 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.avg_ready = avg_ready_s;
    assign bus.dif_ready = dif_ready_s;
    assign bus.sample1   = sample1_r;
    assign bus.sample2   = sample2_r;
    assign bus.sat       = sat_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_rle_idwt_decoder.sv
// Directed self-checking bench for rle_idwt_decoder: queued RLE pairs in,
// collected output beats compared against hand-computed expectations.
module tb_rle_idwt_decoder;

    logic clk;
    logic rst_n;

    rle_idwt_decoder_if #(.W(8), .CW(8)) bus ();

    rle_idwt_decoder #(.W(8), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] avg_q[$];
    logic [15:0] dif_q[$];
    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];
    int          stamp_q[$];
    logic [63:0] rdy_mask;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_avg(input int v, input int c);
        avg_q.push_back({8'(v), 8'(c)});
    endtask

    task automatic push_dif(input int v, input int c);
        dif_q.push_back({8'(v), 8'(c)});
    endtask

    task automatic exp_beat(input int s1, input int s2, input int s);
        exp_q.push_back({8'(s1), 8'(s2), 1'(s)});
    endtask

    task automatic new_test();
        got_q.delete();
        exp_q.delete();
        stamp_q.delete();
        rdy_mask = '1;
    endtask

    task automatic drive_inputs(input int c);
        bus.avg_valid = (avg_q.size() > 0);
        bus.avg_val   = (avg_q.size() > 0) ? avg_q[0][15:8] : 8'sd0;
        bus.avg_cnt   = (avg_q.size() > 0) ? avg_q[0][7:0]  : 8'd0;
        bus.dif_valid = (dif_q.size() > 0);
        bus.dif_val   = (dif_q.size() > 0) ? dif_q[0][15:8] : 8'sd0;
        bus.dif_cnt   = (dif_q.size() > 0) ? dif_q[0][7:0]  : 8'd0;
        bus.out_ready = rdy_mask[c % 64];
    endtask

    // Runs ncyc cycles; called and returns at posedge+1.
    task automatic run(input string name, input int ncyc);
        logic       acc_a, acc_d, hold_pend;
        logic [16:0] prev;
        hold_pend = 1'b0;
        prev      = '0;
        for (int c = 0; c < ncyc; c++) begin
            drive_inputs(c);
            @(negedge clk);
            acc_a = bus.avg_valid && bus.avg_ready;
            acc_d = bus.dif_valid && bus.dif_ready;
            if (hold_pend) begin
                check_val($sformatf("%s.hold_valid.c%0d", name, c), int'(bus.out_valid), 1);
                check_val($sformatf("%s.hold_data.c%0d", name, c),
                          int'({bus.sample1, bus.sample2, bus.sat}), int'(prev));
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            prev      = {bus.sample1, bus.sample2, bus.sat};
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back({bus.sample1, bus.sample2, bus.sat});
                stamp_q.push_back(c);
            end
            @(posedge clk);
            #1;
            if (acc_a) void'(avg_q.pop_front());
            if (acc_d) void'(dif_q.pop_front());
        end
        drive_inputs(ncyc);
    endtask

    task automatic verify(input string name);
        int n;
        check_val({name, ".count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s.b%0d.s1", name, i),
                      int'($signed(got_q[i][16:9])), int'($signed(exp_q[i][16:9])));
            check_val($sformatf("%s.b%0d.s2", name, i),
                      int'($signed(got_q[i][8:1])), int'($signed(exp_q[i][8:1])));
            check_val($sformatf("%s.b%0d.sat", name, i), int'(got_q[i][0]), int'(exp_q[i][0]));
        end
        check_val({name, ".idle"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.avg_valid = 1'b0;
        bus.avg_val   = '0;
        bus.avg_cnt   = '0;
        bus.dif_valid = 1'b0;
        bus.dif_val   = '0;
        bus.dif_cnt   = '0;
        bus.out_ready = 1'b1;
        rdy_mask      = '1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.out_valid", int'(bus.out_valid), 0);
        check_val("rst.sample1", int'(bus.sample1), 0);
        check_val("rst.sample2", int'(bus.sample2), 0);
        check_val("rst.sat", int'(bus.sat), 0);
        check_val("rst.avg_ready", int'(bus.avg_ready), 1);
        check_val("rst.dif_ready", int'(bus.dif_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Equal runs.
        new_test();
        push_avg(10, 3); push_dif(2, 3);
        repeat (3) exp_beat(12, 8, 0);
        run("t1", 12);
        verify("t1");

        // Back-to-back dif runs must not leave a bubble.
        new_test();
        push_avg(5, 4); push_dif(1, 1); push_dif(-1, 3);
        exp_beat(6, 4, 0);
        repeat (3) exp_beat(4, 6, 0);
        run("t2", 14);
        verify("t2");
        if (stamp_q.size() >= 4) check_val("t2.gap", stamp_q[3] - stamp_q[0], 3);

        // Zero-length run is discarded.
        new_test();
        push_avg(0, 2); push_dif(7, 0); push_dif(3, 2);
        repeat (2) exp_beat(3, -3, 0);
        run("t3", 12);
        verify("t3");

        // Positive and negative saturation.
        new_test();
        push_avg(100, 1); push_avg(-128, 1);
        push_dif(100, 1); push_dif(1, 1);
        exp_beat(127, 0, 1);
        exp_beat(-127, -128, 1);
        run("t4", 12);
        verify("t4");

        // Backpressure mid-run.
        new_test();
        push_avg(20, 5); push_dif(0, 5);
        rdy_mask[6:3] = 4'b0000;
        repeat (5) exp_beat(20, 20, 0);
        run("t5", 20);
        verify("t5");

        // Asynchronous reset mid-run.
        new_test();
        push_avg(9, 200); push_dif(0, 200);
        run("t6pre", 5);
        check_val("t6.pre_valid", int'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6.async_valid", int'(bus.out_valid), 0);
        check_val("t6.async_sample1", int'(bus.sample1), 0);
        check_val("t6.async_avg_ready", int'(bus.avg_ready), 1);
        check_val("t6.async_dif_ready", int'(bus.dif_ready), 1);
        avg_q.delete();
        dif_q.delete();
        bus.avg_valid = 1'b0;
        bus.dif_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        new_test();
        push_avg(1, 1); push_dif(1, 1);
        exp_beat(2, 0, 0);
        run("t6", 10);
        verify("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
